// File: rtl/data_mem_lat.sv
// Byte-addressed data memory for the MEM stage.
// Valid/ready request/response with fixed access latency and faults.
package data_mem_lat_pkg;
  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    HWORD = 2'b01,
    WORD  = 2'b10
  } mem_op_sz_e;
endpackage

module data_mem_lat
  import data_mem_lat_pkg::*;
#(
  parameter int unsigned MemoryBytesSize = 1024,
  parameter int unsigned Latency         = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_data,
  input  mem_op_sz_e i_req_size,
  input  logic       i_req_unsigned,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic [1:0] o_rsp_fault
);

  localparam int unsigned AW = $clog2(MemoryBytesSize);
  localparam logic [32:0] MEM_END = 33'(MemoryBytesSize);
  localparam logic [3:0] CNT_INIT = 4'(Latency - 1);
  localparam logic [1:0] FLT_OK = 2'd0;
  localparam logic [1:0] FLT_MIS = 2'd1;
  localparam logic [1:0] FLT_RNG = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic       we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  mem_op_sz_e size_q, size_d;
  logic       uns_q, uns_d;
  logic [1:0] flt_q, flt_d;

  logic       rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0] rsp_flt_q, rsp_flt_d;

  logic [7:0] mem_q [MemoryBytesSize];

  logic       op_we;
  logic [31:0] op_addr;
  logic [31:0] op_data;
  mem_op_sz_e op_size;
  logic       op_uns;
  logic [1:0] op_flt;
  logic [2:0] op_nb;

  logic       enter_resp;
  logic [31:0] raw_word;
  logic [31:0] ld_val;
  logic [AW-1:0] lane_idx [4];
  logic [7:0] lane_rd [4];
  logic [7:0] lane_wd [4];
  logic [3:0] lane_we;

  // Misaligned beats out-of-range; range end computed without wrap.
  function automatic logic [1:0] fault_of(
    input logic [31:0] a,
    input mem_op_sz_e  sz
  );
    logic       mis;
    logic [2:0] nb;
    logic [32:0] end_a;
    mis = 1'b0;
    nb = 3'd1;
    case (sz)
      BYTE: begin
        mis = 1'b0;
        nb = 3'd1;
      end
      HWORD: begin
        mis = a[0];
        nb = 3'd2;
      end
      WORD: begin
        mis = |a[1:0];
        nb = 3'd4;
      end
      default: begin
        mis = 1'b1;
        nb = 3'd1;
      end
    endcase
    end_a = {1'b0, a} + {30'd0, nb};
    if (mis) begin
      return FLT_MIS;
    end else if (end_a > MEM_END) begin
      return FLT_RNG;
    end
    return FLT_OK;
  endfunction

  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_fault = rsp_flt_q;

  // Edge that enters RESP: commits stores and samples loads.
  always_comb begin
    enter_resp = 1'b0;
    if (state_q == S_IDLE) begin
      enter_resp = i_req_valid && (Latency == 1);
    end else if (state_q == S_WAIT) begin
      enter_resp = (cnt_q == 4'd1);
    end
  end

  // Operation in effect: live inputs on accept, latched copy later.
  always_comb begin
    op_we = we_q;
    op_addr = addr_q;
    op_data = data_q;
    op_size = size_q;
    op_uns = uns_q;
    op_flt = flt_q;
    if (state_q == S_IDLE) begin
      op_we = i_req_we;
      op_addr = i_req_addr;
      op_data = i_req_data;
      op_size = i_req_size;
      op_uns = i_req_unsigned;
      op_flt = fault_of(i_req_addr, i_req_size);
    end
    case (op_size)
      BYTE:    op_nb = 3'd1;
      HWORD:   op_nb = 3'd2;
      WORD:    op_nb = 3'd4;
      default: op_nb = 3'd0;
    endcase
  end

  // Byte lanes: little-endian read and store write enables.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_idx[k] = op_addr[AW-1:0] + AW'(k);
      lane_rd[k] = mem_q[lane_idx[k]];
      lane_wd[k] = op_data[8*k +: 8];
      lane_we[k] = enter_resp && op_we &&
                   (op_flt == FLT_OK) && (3'(k) < op_nb);
    end
    raw_word = {lane_rd[3], lane_rd[2], lane_rd[1], lane_rd[0]};
  end

  // Load result with sign/zero extension; zero for stores and faults.
  always_comb begin
    ld_val = 32'd0;
    case (op_size)
      BYTE: begin
        ld_val = op_uns ? {24'd0, raw_word[7:0]}
                        : {{24{raw_word[7]}}, raw_word[7:0]};
      end
      HWORD: begin
        ld_val = op_uns ? {16'd0, raw_word[15:0]}
                        : {{16{raw_word[15]}}, raw_word[15:0]};
      end
      WORD: begin
        ld_val = raw_word;
      end
      default: begin
        ld_val = 32'd0;
      end
    endcase
    if (op_we || (op_flt != FLT_OK)) begin
      ld_val = 32'd0;
    end
  end

  // Next-state and request/response register updates.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    addr_d = addr_q;
    data_d = data_q;
    size_d = size_q;
    uns_d = uns_q;
    flt_d = flt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d = rsp_data_q;
    rsp_flt_d = rsp_flt_q;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          we_d = i_req_we;
          addr_d = i_req_addr;
          data_d = i_req_data;
          size_d = i_req_size;
          uns_d = i_req_unsigned;
          flt_d = op_flt;
          state_d = S_WAIT;
          cnt_d = CNT_INIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (i_rsp_ready) begin
          state_d = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (enter_resp) begin
      state_d = S_RESP;
      cnt_d = 4'd0;
      rsp_valid_d = 1'b1;
      rsp_data_d = ld_val;
      rsp_flt_d = op_flt;
    end
  end

  // Control and response registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q <= 4'd0;
      we_q <= 1'b0;
      addr_q <= 32'd0;
      data_q <= 32'd0;
      size_q <= BYTE;
      uns_q <= 1'b0;
      flt_q <= FLT_OK;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= 32'd0;
      rsp_flt_q <= FLT_OK;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      size_q <= size_d;
      uns_q <= uns_d;
      flt_q <= flt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_flt_q <= rsp_flt_d;
    end
  end

  // Memory array: cleared on reset, byte-lane writes on commit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < MemoryBytesSize; i++) begin
        mem_q[i] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (lane_we[k]) begin
          mem_q[lane_idx[k]] <= lane_wd[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_lat.sv
// Bench for data_mem_lat: directed cases plus random traffic
// against a byte-array reference model.
module tb_data_mem_lat;
  import data_mem_lat_pkg::*;

  localparam int MEM = 1024;
  localparam int LAT = 2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_data;
  mem_op_sz_e  i_req_size;
  logic        i_req_unsigned;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic [1:0]  o_rsp_fault;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mdl [MEM];

  data_mem_lat #(
    .MemoryBytesSize(MEM),
    .Latency(LAT)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_we(i_req_we),
    .i_req_addr(i_req_addr),
    .i_req_data(i_req_data),
    .i_req_size(i_req_size),
    .i_req_unsigned(i_req_unsigned),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data),
    .o_rsp_fault(o_rsp_fault)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int mdl_nb(input logic [1:0] sz);
    case (sz)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] mdl_fault(input logic [31:0] a,
                                           input logic [1:0] sz);
    longint last;
    if (sz == 2'd3) return 2'd1;
    if (sz == 2'd1 && (a % 2) != 0) return 2'd1;
    if (sz == 2'd2 && (a % 4) != 0) return 2'd1;
    last = longint'(a) + longint'(mdl_nb(sz));
    if (last > longint'(MEM)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] a,
                                           input logic [1:0] sz,
                                           input logic uns);
    longint v;
    int nb;
    nb = mdl_nb(sz);
    v = 0;
    for (int k = 0; k < nb; k++) begin
      v += longint'(mdl[int'(a) + k]) << (8 * k);
    end
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) begin
      v -= longint'(1) << (8 * nb);
    end
    return 32'(v);
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < MEM; i++) mdl[i] = 8'd0;
  endtask

  task automatic mdl_apply(input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] sz);
    if (we && mdl_fault(a, sz) == 2'd0) begin
      for (int k = 0; k < mdl_nb(sz); k++) begin
        mdl[int'(a) + k] = 8'((d >> (8 * k)) & 32'hFF);
      end
    end
  endtask

  task automatic scramble();
    i_req_we = 1'($urandom);
    i_req_addr = $urandom;
    i_req_data = $urandom;
    i_req_size = mem_op_sz_e'(2'($urandom));
    i_req_unsigned = 1'($urandom);
  endtask

  // One full request/response with fixed expectations.
  task automatic txn(input string tag, input logic we,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input logic uns,
                     input int hold, input logic [31:0] exp_d,
                     input logic [1:0] exp_f);
    int t;
    int lat;
    t = 0;
    while (!o_req_ready && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    chk({tag, ".req_ready"}, 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1;
    i_req_we = we;
    i_req_addr = a;
    i_req_data = d;
    i_req_size = mem_op_sz_e'(sz);
    i_req_unsigned = uns;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    scramble();
    lat = 0;
    @(negedge i_clk);
    while (!o_rsp_valid && lat < 40) begin
      @(negedge i_clk);
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(LAT - 1));
    chk({tag, ".data"}, o_rsp_data, exp_d);
    chk({tag, ".fault"}, 32'(o_rsp_fault), 32'(exp_f));
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      chk({tag, ".hold_valid"}, 32'(o_rsp_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(o_req_ready), 32'd0);
      chk({tag, ".hold_data"}, o_rsp_data, exp_d);
      chk({tag, ".hold_fault"}, 32'(o_rsp_fault), 32'(exp_f));
    end
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    chk({tag, ".done_valid"}, 32'(o_rsp_valid), 32'd0);
    chk({tag, ".done_ready"}, 32'(o_req_ready), 32'd1);
    i_rsp_ready = 1'b0;
    mdl_apply(we, a, d, sz);
  endtask

  // Request with expectations taken from the reference model.
  task automatic mtxn(input string tag, input logic we,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic uns,
                      input int hold);
    logic [1:0] f;
    logic [31:0] e;
    f = mdl_fault(a, sz);
    e = (we || f != 2'd0) ? 32'd0 : mdl_load(a, sz, uns);
    txn(tag, we, a, d, sz, uns, hold, e, f);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    mdl_clear();
    @(negedge i_clk);
  endtask

  initial begin
    int acc [$];
    int r;
    logic [31:0] a;
    logic [1:0] sz;

    i_rst = 1'b0;
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b0;
    scramble();
    mdl_clear();
    @(negedge i_clk);
    do_reset();

    chk("rst.req_ready", 32'(o_req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst.rsp_data", o_rsp_data, 32'd0);
    chk("rst.rsp_fault", 32'(o_rsp_fault), 32'd0);

    txn("ld0", 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 0, 32'h0, 2'd0);

    txn("st8", 1'b1, 32'h8, 32'hDEADBEEF, 2'd2, 1'b0, 0, 32'h0, 2'd0);
    txn("lbB_s", 1'b0, 32'hB, 32'h0, 2'd0, 1'b0, 0, 32'hFFFFFFDE, 2'd0);
    txn("lbB_u", 1'b0, 32'hB, 32'h0, 2'd0, 1'b1, 0, 32'h000000DE, 2'd0);
    txn("lh8_s", 1'b0, 32'h8, 32'h0, 2'd1, 1'b0, 0, 32'hFFFFBEEF, 2'd0);
    txn("lh8_u", 1'b0, 32'h8, 32'h0, 2'd1, 1'b1, 0, 32'h0000BEEF, 2'd0);
    txn("lw8", 1'b0, 32'h8, 32'h0, 2'd2, 1'b0, 0, 32'hDEADBEEF, 2'd0);

    txn("st0", 1'b1, 32'h0, 32'h11223344, 2'd2, 1'b0, 0, 32'h0, 2'd0);
    txn("sh3", 1'b1, 32'h3, 32'hAAAA5555, 2'd1, 1'b0, 0, 32'h0, 2'd1);
    txn("lw0", 1'b0, 32'h0, 32'h0, 2'd2, 1'b1, 0, 32'h11223344, 2'd0);
    txn("lw6", 1'b0, 32'h6, 32'h0, 2'd2, 1'b0, 0, 32'h0, 2'd1);
    txn("bad_sz", 1'b1, 32'h0, 32'hFFFFFFFF, 2'd3, 1'b0, 0, 32'h0, 2'd1);
    txn("lw0b", 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 0, 32'h11223344, 2'd0);

    txn("lw_end2", 1'b0, 32'(MEM - 2), 32'h0, 2'd2, 1'b0, 0, 32'h0, 2'd1);
    txn("lw_end", 1'b0, 32'(MEM), 32'h0, 2'd2, 1'b0, 0, 32'h0, 2'd2);
    txn("lb_last", 1'b0, 32'(MEM - 1), 32'h0, 2'd0, 1'b0, 0, 32'h0, 2'd0);
    txn("lh_last", 1'b0, 32'(MEM - 2), 32'h0, 2'd1, 1'b0, 0, 32'h0, 2'd0);
    txn("lw_wrap", 1'b0, 32'hFFFFFFFC, 32'h0, 2'd2, 1'b0, 0, 32'h0, 2'd2);
    txn("sb_last", 1'b1, 32'(MEM - 1), 32'h00000080, 2'd0, 1'b0, 0, 32'h0, 2'd0);
    txn("lb_last_s", 1'b0, 32'(MEM - 1), 32'h0, 2'd0, 1'b0, 0, 32'hFFFFFF80, 2'd0);
    txn("sw_oor", 1'b1, 32'(MEM), 32'h12345678, 2'd2, 1'b0, 0, 32'h0, 2'd2);

    txn("hold5", 1'b0, 32'h8, 32'h0, 2'd2, 1'b0, 5, 32'hDEADBEEF, 2'd0);

    // Back-to-back: valid and rsp_ready both held high.
    i_req_valid = 1'b1;
    i_req_we = 1'b0;
    i_req_addr = 32'h8;
    i_req_size = WORD;
    i_req_unsigned = 1'b0;
    i_rsp_ready = 1'b1;
    for (int c = 0; c < 6 * (LAT + 1) && acc.size() < 3; c++) begin
      if (o_req_ready) acc.push_back(c);
      @(negedge i_clk);
    end
    while (acc.size() < 3) acc.push_back(-1000);
    chk("b2b.gap1", 32'(acc[1] - acc[0]), 32'(LAT + 1));
    chk("b2b.gap2", 32'(acc[2] - acc[1]), 32'(LAT + 1));
    i_req_valid = 1'b0;
    repeat (LAT + 4) @(negedge i_clk);
    i_rsp_ready = 1'b0;
    chk("b2b.idle", 32'(o_req_ready), 32'd1);

    // Reset while a store is in flight.
    i_req_valid = 1'b1;
    i_req_we = 1'b1;
    i_req_addr = 32'h10;
    i_req_data = 32'hCAFEF00D;
    i_req_size = WORD;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    mdl_clear();
    i_rsp_ready = 1'b1;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge i_clk);
      chk("rst_wait.valid", 32'(o_rsp_valid), 32'd0);
      chk("rst_wait.ready", 32'(o_req_ready), 32'd1);
    end
    i_rsp_ready = 1'b0;
    txn("rst_ld10", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, 32'h0, 2'd0);
    txn("rst_ld8", 1'b0, 32'h8, 32'h0, 2'd2, 1'b0, 0, 32'h0, 2'd0);

    // Random traffic against the model.
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      sz = (r == 9) ? 2'd3 : 2'(r % 3);
      case ($urandom_range(0, 3))
        0: a = 32'($urandom_range(0, 63));
        1: a = 32'(MEM - $urandom_range(1, 6));
        2: a = $urandom;
        default: a = 32'($urandom_range(0, MEM - 1));
      endcase
      mtxn("rnd", 1'($urandom), a, $urandom, sz, 1'($urandom),
           $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
